// File: rtl/dll_tx_fc_gate_pkg.sv
// Shared types and constants for the DLL transmit flow-control gate and its per-class trackers.
package dll_tx_fc_gate_pkg;
  localparam int CREDIT_DEPTH_DEF = 12;
  localparam int HDR_WIDTH_DEF    = 8;

  typedef enum logic [1:0] {
    TLP_P   = 2'd0,
    TLP_NP  = 2'd1,
    TLP_CPL = 2'd2
  } tlp_class_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_ACTIVE = 2'd2
  } fc_state_t;

  // DLLP FC type codes (upper nibble of DLLP byte 0), shared with the decoder
  localparam logic [7:0] DLLP_INITFC1_P   = 8'h40;
  localparam logic [7:0] DLLP_INITFC1_NP  = 8'h50;
  localparam logic [7:0] DLLP_INITFC1_CPL = 8'h60;
  localparam logic [7:0] DLLP_INITFC2_P   = 8'hC0;
  localparam logic [7:0] DLLP_INITFC2_NP  = 8'hD0;
  localparam logic [7:0] DLLP_INITFC2_CPL = 8'hE0;
  localparam logic [7:0] DLLP_UPDFC_P     = 8'h80;
  localparam logic [7:0] DLLP_UPDFC_NP    = 8'h90;
  localparam logic [7:0] DLLP_UPDFC_CPL   = 8'hA0;
endpackage

// File: rtl/dll_tx_fc_gate_if.sv
// TLP transmit request handshake between the transaction layer and the flow-control gate.
interface dll_tx_fc_gate_if
  import dll_tx_fc_gate_pkg::*;
#(
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF
);
  logic                    tlp_req_valid_i;
  logic [1:0]              tlp_req_class_i;
  logic [CREDIT_DEPTH-1:0] tlp_req_dcred_i;
  logic                    tlp_req_ready_o;

  modport master (
    output tlp_req_valid_i, tlp_req_class_i, tlp_req_dcred_i,
    input  tlp_req_ready_o
  );

  modport slave (
    input  tlp_req_valid_i, tlp_req_class_i, tlp_req_dcred_i,
    output tlp_req_ready_o
  );
endinterface

// File: rtl/dll_tx_fc_gate_tracker.sv
// Per-class credit tracker: credit limit, consumed count, last-seen UpdateFC and admission check.
module dll_fc_class_tracker
  import dll_tx_fc_gate_pkg::*;
#(
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  parameter int HDR_WIDTH    = HDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    latch_cl,
  input  logic                    snap_cc,
  input  logic                    active,
  input  logic                    grant,
  input  logic [CREDIT_DEPTH-1:0] dcred,
  input  logic [CREDIT_DEPTH-1:0] cl_h_in,
  input  logic [CREDIT_DEPTH-1:0] cl_d_in,
  input  logic [CREDIT_DEPTH-1:0] cc_h_in,
  input  logic [CREDIT_DEPTH-1:0] cc_d_in,
  output logic                    ok,
  output logic [HDR_WIDTH-1:0]    cc_h,
  output logic [CREDIT_DEPTH-1:0] cc_d
);
  localparam logic [HDR_WIDTH:0]    H_HALF = {2'b01, {(HDR_WIDTH-1){1'b0}}};
  localparam logic [CREDIT_DEPTH:0] D_HALF = {2'b01, {(CREDIT_DEPTH-1){1'b0}}};

  logic [HDR_WIDTH-1:0]    cl_h;
  logic [CREDIT_DEPTH-1:0] cl_d;
  logic [CREDIT_DEPTH-1:0] last_h;
  logic [CREDIT_DEPTH-1:0] last_d;
  logic                    inf_h;
  logic                    inf_d;
  logic [HDR_WIDTH-1:0]    hdr_room;
  logic [CREDIT_DEPTH-1:0] data_room;
  logic                    hdr_ok;
  logic                    data_ok;

  // Remaining credit after this TLP, modulo the counter width; a "negative" result lands above half range
  assign hdr_room  = cl_h - (cc_h + HDR_WIDTH'(1));
  assign data_room = cl_d - (cc_d + dcred);
  assign hdr_ok    = inf_h || ({1'b0, hdr_room} <= H_HALF);
  assign data_ok   = inf_d || (dcred == '0) || ({1'b0, data_room} <= D_HALF);
  assign ok        = hdr_ok && data_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      cl_h   <= '0;
      cl_d   <= '0;
      last_h <= '0;
      last_d <= '0;
      inf_h  <= 1'b0;
      inf_d  <= 1'b0;
      cc_h   <= '0;
      cc_d   <= '0;
    end else begin
      if (latch_cl) begin
        cl_h  <= cl_h_in[HDR_WIDTH-1:0];
        cl_d  <= cl_d_in;
        inf_h <= (cl_h_in == '0);
        inf_d <= (cl_d_in == '0);
      end
      if (snap_cc) begin
        last_h <= cc_h_in;
        last_d <= cc_d_in;
      end
      if (active) begin
        if (cc_h_in != last_h) begin
          last_h <= cc_h_in;
          if (!inf_h) cl_h <= cc_h_in[HDR_WIDTH-1:0];
        end
        if (cc_d_in != last_d) begin
          last_d <= cc_d_in;
          if (!inf_d) cl_d <= cc_d_in;
        end
      end
      if (grant) begin
        cc_h <= cc_h + HDR_WIDTH'(1);
        cc_d <= cc_d + dcred;
      end
    end
  end
endmodule

// File: rtl/dll_tx_fc_gate.sv
// Transmit flow-control gate: init FSM, per-class credit trackers and TLP grant mux.
// Optional TX_FC_STALL_CNT_EN adds a saturating stall_cnt_o of active stalled cycles.
module dll_tx_fc_gate
  import dll_tx_fc_gate_pkg::*;
#(
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  parameter int HDR_WIDTH    = HDR_WIDTH_DEF
) (
  input  logic                    sclk,
  input  logic                    srst,
  input  logic                    init1_received_i,
  input  logic                    init2_received_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cl_p_h_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cl_np_h_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cl_cpl_h_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cl_p_d_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cl_np_d_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cl_cpl_d_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cc_p_h_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cc_np_h_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cc_cpl_h_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cc_p_d_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cc_np_d_i,
  input  logic [CREDIT_DEPTH-1:0] ep_cc_cpl_d_i,
  dll_tx_fc_gate_if.slave         tlp,
  output logic                    fc_active_o,
  output logic [HDR_WIDTH-1:0]    cc_p_h_o,
  output logic [HDR_WIDTH-1:0]    cc_np_h_o,
  output logic [HDR_WIDTH-1:0]    cc_cpl_h_o,
  output logic [CREDIT_DEPTH-1:0] cc_p_d_o,
  output logic [CREDIT_DEPTH-1:0] cc_np_d_o,
  output logic [CREDIT_DEPTH-1:0] cc_cpl_d_o
`ifdef TX_FC_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt_o
`endif
);
  fc_state_t state_q, state_d;
  logic      active, latch_cl, snap_cc;
  logic      ok_p, ok_np, ok_cpl, class_ok, ready;
  logic      grant_p, grant_np, grant_cpl;

  always_ff @(posedge sclk) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (init1_received_i) state_d = S_INIT;
      S_INIT:   if (init2_received_i) state_d = S_ACTIVE;
      S_ACTIVE: state_d = S_ACTIVE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign active   = (state_q == S_ACTIVE);
  assign latch_cl = (state_q == S_IDLE) && init1_received_i;
  assign snap_cc  = (state_q == S_INIT) && init2_received_i;

  always_comb begin
    class_ok = 1'b0;
    case (tlp.tlp_req_class_i)
      TLP_P:   class_ok = ok_p;
      TLP_NP:  class_ok = ok_np;
      TLP_CPL: class_ok = ok_cpl;
      default: class_ok = 1'b0;
    endcase
  end

  assign ready               = active && tlp.tlp_req_valid_i && class_ok;
  assign tlp.tlp_req_ready_o = ready;
  assign fc_active_o         = active;
  assign grant_p             = ready && (tlp.tlp_req_class_i == TLP_P);
  assign grant_np            = ready && (tlp.tlp_req_class_i == TLP_NP);
  assign grant_cpl           = ready && (tlp.tlp_req_class_i == TLP_CPL);

  dll_fc_class_tracker #(.CREDIT_DEPTH(CREDIT_DEPTH), .HDR_WIDTH(HDR_WIDTH)) u_trk_p (
    .clk(sclk), .rst(srst), .latch_cl(latch_cl), .snap_cc(snap_cc), .active(active),
    .grant(grant_p), .dcred(tlp.tlp_req_dcred_i),
    .cl_h_in(ep_cl_p_h_i), .cl_d_in(ep_cl_p_d_i), .cc_h_in(ep_cc_p_h_i), .cc_d_in(ep_cc_p_d_i),
    .ok(ok_p), .cc_h(cc_p_h_o), .cc_d(cc_p_d_o)
  );

  dll_fc_class_tracker #(.CREDIT_DEPTH(CREDIT_DEPTH), .HDR_WIDTH(HDR_WIDTH)) u_trk_np (
    .clk(sclk), .rst(srst), .latch_cl(latch_cl), .snap_cc(snap_cc), .active(active),
    .grant(grant_np), .dcred(tlp.tlp_req_dcred_i),
    .cl_h_in(ep_cl_np_h_i), .cl_d_in(ep_cl_np_d_i), .cc_h_in(ep_cc_np_h_i), .cc_d_in(ep_cc_np_d_i),
    .ok(ok_np), .cc_h(cc_np_h_o), .cc_d(cc_np_d_o)
  );

  dll_fc_class_tracker #(.CREDIT_DEPTH(CREDIT_DEPTH), .HDR_WIDTH(HDR_WIDTH)) u_trk_cpl (
    .clk(sclk), .rst(srst), .latch_cl(latch_cl), .snap_cc(snap_cc), .active(active),
    .grant(grant_cpl), .dcred(tlp.tlp_req_dcred_i),
    .cl_h_in(ep_cl_cpl_h_i), .cl_d_in(ep_cl_cpl_d_i), .cc_h_in(ep_cc_cpl_h_i), .cc_d_in(ep_cc_cpl_d_i),
    .ok(ok_cpl), .cc_h(cc_cpl_h_o), .cc_d(cc_cpl_d_o)
  );

`ifdef TX_FC_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge sclk) begin
    if (srst) stall_cnt_o <= '0;
    else if (active && tlp.tlp_req_valid_i && !ready) stall_cnt_o <= sat_inc16(stall_cnt_o);
  end
`endif
endmodule

// File: tb/tb_dll_tx_fc_gate.sv
// Randomized + directed self-checking bench for dll_tx_fc_gate against a credit-arithmetic reference model.
module tb_dll_tx_fc_gate;
  localparam int HMASK = 255;
  localparam int DMASK = 4095;
  localparam int HHALF = 128;
  localparam int DHALF = 2048;

  logic        sclk = 1'b0;
  logic        srst = 1'b1;
  logic        init1 = 1'b0;
  logic        init2 = 1'b0;
  logic [11:0] cl_h [3];
  logic [11:0] cl_d [3];
  logic [11:0] ep_h [3];
  logic [11:0] ep_d [3];
  logic        fc_active;
  logic [7:0]  cch [3];
  logic [11:0] ccd [3];
`ifdef TX_FC_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  dll_tx_fc_gate_if #(.CREDIT_DEPTH(12)) tif ();

  dll_tx_fc_gate #(.CREDIT_DEPTH(12), .HDR_WIDTH(8)) dut (
    .sclk(sclk), .srst(srst),
    .init1_received_i(init1), .init2_received_i(init2),
    .ep_cl_p_h_i(cl_h[0]), .ep_cl_np_h_i(cl_h[1]), .ep_cl_cpl_h_i(cl_h[2]),
    .ep_cl_p_d_i(cl_d[0]), .ep_cl_np_d_i(cl_d[1]), .ep_cl_cpl_d_i(cl_d[2]),
    .ep_cc_p_h_i(ep_h[0]), .ep_cc_np_h_i(ep_h[1]), .ep_cc_cpl_h_i(ep_h[2]),
    .ep_cc_p_d_i(ep_d[0]), .ep_cc_np_d_i(ep_d[1]), .ep_cc_cpl_d_i(ep_d[2]),
    .tlp(tif),
    .fc_active_o(fc_active),
    .cc_p_h_o(cch[0]), .cc_np_h_o(cch[1]), .cc_cpl_h_o(cch[2]),
    .cc_p_d_o(ccd[0]), .cc_np_d_o(ccd[1]), .cc_cpl_d_o(ccd[2])
`ifdef TX_FC_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: link-partner limits and consumed credits as plain integers
  int  mstate;
  int  lim_h [3], lim_d [3], cons_h [3], cons_d [3], seen_h [3], seen_d [3];
  bit  inf_h [3], inf_d [3];
  int  m_stall;
  bit  last_rdy;
  string cname [3] = '{"p", "np", "cpl"};

  function automatic void model_reset();
    mstate = 0;
    m_stall = 0;
    for (int c = 0; c < 3; c++) begin
      lim_h[c] = 0; lim_d[c] = 0; cons_h[c] = 0; cons_d[c] = 0;
      seen_h[c] = 0; seen_d[c] = 0; inf_h[c] = 0; inf_d[c] = 0;
    end
  endfunction

  function automatic bit m_fits(int c, int dc);
    bit h_ok, d_ok;
    h_ok = inf_h[c] || (((lim_h[c] - cons_h[c] - 1) & HMASK) <= HHALF);
    d_ok = inf_d[c] || (dc == 0) || (((lim_d[c] - cons_d[c] - dc) & DMASK) <= DHALF);
    return h_ok && d_ok;
  endfunction

  task automatic step();
    int  c, dc, old;
    bit  exp_rdy;
    #1;
    c  = int'(tif.tlp_req_class_i);
    dc = int'(tif.tlp_req_dcred_i);
    exp_rdy = (mstate == 2) && tif.tlp_req_valid_i && (c != 3) && m_fits(c, dc);
    check_eq("ready", tif.tlp_req_ready_o, exp_rdy);
    last_rdy = exp_rdy;
    old = mstate;
    if (srst) begin
      model_reset();
    end else begin
      if (old == 2 && tif.tlp_req_valid_i && !exp_rdy && m_stall < 65535) m_stall++;
      if (exp_rdy) begin
        cons_h[c] = (cons_h[c] + 1) & HMASK;
        cons_d[c] = (cons_d[c] + dc) & DMASK;
      end
      if (old == 2) begin
        for (int k = 0; k < 3; k++) begin
          if (int'(ep_h[k]) != seen_h[k]) begin
            seen_h[k] = int'(ep_h[k]);
            if (!inf_h[k]) lim_h[k] = int'(ep_h[k]) & HMASK;
          end
          if (int'(ep_d[k]) != seen_d[k]) begin
            seen_d[k] = int'(ep_d[k]);
            if (!inf_d[k]) lim_d[k] = int'(ep_d[k]);
          end
        end
      end else if (old == 0 && init1) begin
        for (int k = 0; k < 3; k++) begin
          lim_h[k] = int'(cl_h[k]) & HMASK; inf_h[k] = (cl_h[k] == 0);
          lim_d[k] = int'(cl_d[k]);         inf_d[k] = (cl_d[k] == 0);
        end
        mstate = 1;
      end else if (old == 1 && init2) begin
        for (int k = 0; k < 3; k++) begin
          seen_h[k] = int'(ep_h[k]); seen_d[k] = int'(ep_d[k]);
        end
        mstate = 2;
      end
    end
    @(posedge sclk);
    #1;
    check_eq("fc_active", fc_active, (mstate == 2));
    for (int k = 0; k < 3; k++) begin
      check_eq({"cc_h_", cname[k]}, cch[k], cons_h[k]);
      check_eq({"cc_d_", cname[k]}, ccd[k], cons_d[k]);
    end
`ifdef TX_FC_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic req(input bit v, input logic [1:0] cls, input logic [11:0] dc);
    tif.tlp_req_valid_i = v;
    tif.tlp_req_class_i = cls;
    tif.tlp_req_dcred_i = dc;
  endtask

  task automatic do_init();
    init1 = 1'b1; step(); init1 = 1'b0;
    init2 = 1'b1; step(); init2 = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cl_h[k] = '0; cl_d[k] = '0; ep_h[k] = '0; ep_d[k] = '0;
    end
    req(1'b0, 2'd0, 12'd0);
    repeat (2) @(posedge sclk);
    #1;
    model_reset();
    check_eq("rst_active", fc_active, 0);
    check_eq("rst_ready", tif.tlp_req_ready_o, 0);
    check_eq("rst_cc_p_h", cch[0], 0);
    check_eq("rst_cc_cpl_d", ccd[2], 0);
    srst = 1'b0;

    // Init with mixed finite/infinite limits; requests before active must stall
    cl_h[0] = 12'd4; cl_d[0] = 12'd16;
    cl_h[1] = 12'd2; cl_d[1] = 12'd0;
    cl_h[2] = 12'd0; cl_d[2] = 12'd0;
    init1 = 1'b1; step(); init1 = 1'b0;
    req(1'b1, 2'd0, 12'd4); step();
    req(1'b1, 2'd3, 12'd0); step();
    check_eq("pre_cc_p_h", cch[0], 0);
    req(1'b0, 2'd0, 12'd0);
    init2 = 1'b1; step(); init2 = 1'b0;
    check_eq("t1_active", fc_active, 1);
    req(1'b1, 2'd1, 12'd100); step();
    req(1'b1, 2'd2, 12'd50);  step();
    check_eq("t1_np_d_inf", ccd[1], 100);
    check_eq("t1_cpl_d_inf", ccd[2], 50);

    // Exhaust P, then release via UpdateFC
    req(1'b1, 2'd0, 12'd4);
    repeat (4) step();
    check_eq("t2_cc_h", cch[0], 4);
    check_eq("t2_cc_d", ccd[0], 16);
    repeat (3) step();
    check_eq("t2_stall", tif.tlp_req_ready_o, 0);
    ep_h[0] = 12'd6; ep_d[0] = 12'd24;
    #1 check_eq("t2_upd_cyc0", tif.tlp_req_ready_o, 0);
    step();
    #1 check_eq("t2_upd_cyc1", tif.tlp_req_ready_o, 1);
    step();
    check_eq("t2_cc_h5", cch[0], 5);

    // Drive P header consumption up to 0xFF, then wrap
    for (int i = 0; i < 700 && cons_h[0] != 255; i++) begin
      req(1'b1, 2'd0, 12'd0);
      if (!m_fits(0, 0)) ep_h[0] = 12'((cons_h[0] + 64) & HMASK);
      step();
    end
    req(1'b0, 2'd0, 12'd0);
    check_eq("t3_reach", cch[0], 8'hFF);
    ep_h[0] = 12'h002; step();
    req(1'b1, 2'd0, 12'd0);
    #1 check_eq("t3_rdy_wrap", tif.tlp_req_ready_o, 1);
    step();
    check_eq("t3_cc_wrap", cch[0], 8'h00);
    step(); step();
    check_eq("t3_cc_2", cch[0], 8'h02);
    #1 check_eq("t3_stall", tif.tlp_req_ready_o, 0);

    // Grant and UpdateFC on the same class in the same cycle
    req(1'b0, 2'd0, 12'd0);
    ep_h[0] = 12'd16; step();
    req(1'b1, 2'd0, 12'd2); ep_d[0] = 12'd40;
    #1 check_eq("t4_rdy_a", tif.tlp_req_ready_o, 1);
    step();
    check_eq("t4_cc_d", ccd[0], 22);
    req(1'b1, 2'd0, 12'd18);
    #1 check_eq("t4_rdy_b", tif.tlp_req_ready_o, 1);
    step();
    check_eq("t4_cc_d2", ccd[0], 40);
    req(1'b1, 2'd0, 12'd1);
    #1 check_eq("t4_stall", tif.tlp_req_ready_o, 0);
    step();

    // Illegal class, then reset in the middle of a burst
    req(1'b1, 2'd3, 12'd1);
    #1 check_eq("t5_cls3", tif.tlp_req_ready_o, 0);
    step();
    req(1'b1, 2'd2, 12'd5);
    repeat (3) step();
    srst = 1'b1; step(); srst = 1'b0;
    check_eq("t5_rst_active", fc_active, 0);
    check_eq("t5_rst_cpl_d", ccd[2], 0);
    check_eq("t5_rst_p_h", cch[0], 0);
    req(1'b0, 2'd0, 12'd0);

`ifdef TX_FC_STALL_CNT_EN
    cl_h[0] = 12'd1; cl_d[0] = 12'd0;
    do_init();
    req(1'b1, 2'd0, 12'd0);
    step();
    repeat (10) step();
    check_eq("t6_stall_cnt", stall_cnt, 10);
    req(1'b0, 2'd0, 12'd0);
    srst = 1'b1; step(); srst = 1'b0;
`endif

    // Randomized traffic with random limits and UpdateFC activity
    for (int run = 0; run < 2; run++) begin
      srst = 1'b1; step(); srst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cl_h[k] = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 20));
        cl_d[k] = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 200));
        ep_h[k] = cl_h[k];
        ep_d[k] = cl_d[k];
      end
      do_init();
      last_rdy = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if (!(tif.tlp_req_valid_i && !last_rdy)) begin
          int r;
          r = $urandom_range(0, 9);
          req($urandom_range(0, 3) != 0, (r == 9) ? 2'd3 : 2'(r % 3),
              ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom_range(1, 16)));
        end
        if ($urandom_range(0, 7) == 0) begin
          int c;
          c = $urandom_range(0, 2);
          ep_h[c] = ep_h[c] + 12'($urandom_range(0, 3));
          ep_d[c] = ep_d[c] + 12'($urandom_range(0, 40));
        end
        step();
      end
      req(1'b0, 2'd0, 12'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
